piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter with a valid/ready load handshake.
- Drives a single-bit serial line that a clocked flip-flop sampler captures bit by bit.
- Each word goes out as a fixed-length burst, each bit held for a programmable number of clock cycles.
- Companion stimulus and driver block for the sequential-logic sample set.

Parameters:
- WIDTH, 8, bits per word; legal range >= 2.
- CLKS_PER_BIT, 1, clock cycles each bit is held on sout; legal range >= 1.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0, value driven on sout whenever no bit is being sent.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- load_valid, input, 1, load_data is valid this cycle.
- load_data, input, WIDTH, word to serialize.
- load_ready, output, 1, block can accept a word this cycle.
- sout, output, 1, serial data out.
- sout_valid, output, 1, high while sout carries a data bit.
- busy, output, 1, high in SHIFT and DONE states.
- done, output, 1, one-cycle pulse after the last bit of a word.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clk, rst).
- All outputs are registered; no combinational path from inputs to outputs.
- Reset values: state=IDLE, load_ready=1, sout=IDLE_LEVEL, sout_valid=0, busy=0, done=0, shift register=0, bit counter=0, period counter=0.
- Counter widths: bit counter $clog2(WIDTH), period counter $clog2(CLKS_PER_BIT) (minimum 1 bit each).
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - load_ready=1, sout=IDLE_LEVEL, sout_valid=0.
  - Accept on the edge where load_valid && load_ready; call it edge E.
  - At edge E: capture load_data, clear both counters, move to SHIFT.
  - At edge E: load_ready goes 0, busy goes 1.
  - At edge E: sout takes the first bit (MSB_FIRST selects bit WIDTH-1 or bit 0) and sout_valid goes 1.
- SHIFT:
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - At the end of a bit period, the next bit is presented and the period counter wraps to 0.
  - Bit k is on sout during cycles E+k*CLKS_PER_BIT through E+(k+1)*CLKS_PER_BIT-1.
  - After the last bit's period: move to DONE, sout=IDLE_LEVEL, sout_valid=0, done=1.
- DONE:
  - Lasts exactly one cycle: done=1, busy=1, load_ready=0.
  - Next edge: IDLE, done=0, busy=0, load_ready=1.
- Timing:
  - Minimum spacing between accepted words: WIDTH*CLKS_PER_BIT+2 cycles.
  - Latency from the accept edge to the first bit on sout: 0 cycles (visible immediately after edge E).
- load_valid while busy is ignored: the shift register is not altered and the word is not queued. Upstream must hold load_valid until load_ready.
- load_data is sampled only at the accept edge; changes afterwards have no effect on the frame.
- CLKS_PER_BIT=1: bit period counter is unused and each bit lasts one cycle.
- Reset asserted mid-frame:
  - Outputs return to reset values immediately, without waiting for a clock edge.
  - The partial word is discarded and done is not pulsed.
- After reset is released, the first accept may occur on the first clock edge.

Test Plan:
- Reset, then WIDTH=8, CLKS_PER_BIT=1, MSB_FIRST=1, load 8'hA5 -> sout 1,0,1,0,0,1,0,1 on 8 consecutive cycles with sout_valid=1. Then done=1 for one cycle and load_ready=1 the following cycle.
- MSB_FIRST=0, load 8'h01 -> sout 1,0,0,0,0,0,0,0. sout returns to 0 (IDLE_LEVEL) in the DONE cycle.
- CLKS_PER_BIT=4, load 8'hC3 -> each bit held exactly 4 cycles. Frame of 32 data cycles, done at cycle E+32, next accept possible at edge E+34.
- Mid-frame, drive load_valid=1 with load_data=8'hFF -> no change to the bits of the ongoing 8'h5A frame, and no second frame starts until load_ready=1.
- Assert rst between clock edges during bit 3 -> sout=IDLE_LEVEL, sout_valid=0, busy=0, load_ready=1 without waiting for a clock edge. done stays 0.
- Keep load_valid=1 continuously with words 8'h12 and 8'h34 -> exactly one DONE cycle plus one IDLE cycle between frames, and both words serialized intact.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with a valid/ready load port.
// Each word leaves as WIDTH bits, each held CLKS_PER_BIT cycles, then a one-cycle done pulse.
module piso_serializer #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 1,
    parameter int IDLE_LEVEL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);
    // Handshake: a word is taken on the rising edge where load_valid && load_ready;
    // load_ready is high only in IDLE, and load_valid while busy is simply ignored.
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PER_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(CLKS_PER_BIT - 1);
    localparam logic IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic MSB_SEL  = (MSB_FIRST != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] shreg;
    logic [BIT_W-1:0] bit_cnt;
    logic [PER_W-1:0] per_cnt;
    logic             accept;
    logic             bit_end;
    logic             last_bit;
    logic             sout_d;

    assign accept   = (state == ST_IDLE) && load_valid && load_ready;
    assign bit_end  = (per_cnt == PER_LAST);
    assign last_bit = bit_end && (bit_cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (accept)   state_d = ST_SHIFT;
            ST_SHIFT: if (last_bit) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The bit for the coming cycle: first bit straight from load_data on accept,
    // the next register bit at a period boundary, otherwise hold.
    always_comb begin
        sout_d = IDLE_BIT;
        if (state_d == ST_SHIFT) begin
            if (accept) begin
                sout_d = MSB_SEL ? load_data[WIDTH-1] : load_data[0];
            end else if (bit_end) begin
                sout_d = MSB_SEL ? shreg[WIDTH-2] : shreg[1];
            end else begin
                sout_d = sout;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_ready <= 1'b1;
            sout       <= IDLE_BIT;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            load_ready <= (state_d == ST_IDLE);
            sout       <= sout_d;
            sout_valid <= (state_d == ST_SHIFT);
            busy       <= (state_d != ST_IDLE);
            done       <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
            per_cnt <= '0;
        end else if (accept) begin
            shreg   <= load_data;
            bit_cnt <= '0;
            per_cnt <= '0;
        end else if (state == ST_SHIFT) begin
            if (bit_end) begin
                per_cnt <= '0;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                shreg   <= MSB_SEL ? (shreg << 1) : (shreg >> 1);
            end else begin
                per_cnt <= per_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (MSB-first, LSB-first, 4 clocks/bit) checked
// every cycle against a timing model computed from the accept cycle and the accepted word.
module tb_piso_serializer;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lv [3];
    logic [7:0] ld [3];
    logic       lr [3];
    logic       so [3];
    logic       sv [3];
    logic       bz [3];
    logic       dn [3];

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    bit         acc_v [3];
    int         acc_c [3];
    logic [7:0] acc_w [3];
    logic [7:0] exp_q [$];
    logic [7:0] cap = 8'h00;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1), .IDLE_LEVEL(0)) u0 (
        .clk(clk), .rst(rst), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
        .sout(so[0]), .sout_valid(sv[0]), .busy(bz[0]), .done(dn[0]));
    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(0), .IDLE_LEVEL(0)) u1 (
        .clk(clk), .rst(rst), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
        .sout(so[1]), .sout_valid(sv[1]), .busy(bz[1]), .done(dn[1]));
    piso_serializer #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(1), .IDLE_LEVEL(0)) u2 (
        .clk(clk), .rst(rst), .load_valid(lv[2]), .load_data(ld[2]), .load_ready(lr[2]),
        .sout(so[2]), .sout_valid(sv[2]), .busy(bz[2]), .done(dn[2]));

    function automatic int cpb(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    // Free to accept once the frame (W*cpb data cycles + 1 done cycle) has fully elapsed.
    function automatic bit model_ready(input int i, input int c);
        return !acc_v[i] || ((c - acc_c[i]) >= W * cpb(i) + 1);
    endfunction

    // {load_ready, busy, sout_valid, sout, done} expected in cycle c.
    function automatic logic [4:0] model_out(input int i, input int c);
        int   d;
        int   k;
        logic b;
        if (rst || !acc_v[i]) return 5'b10000;
        d = c - acc_c[i];
        if (d < W * cpb(i)) begin
            k = d / cpb(i);
            b = (i == 1) ? acc_w[i][k] : acc_w[i][W-1-k];
            return {3'b011, b, 1'b0};
        end
        if (d == W * cpb(i)) return 5'b01001;
        return 5'b10000;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            if (!rst && lv[i] && model_ready(i, cyc - 1)) begin
                acc_v[i] = 1'b1;
                acc_c[i] = cyc;
                acc_w[i] = ld[i];
                if (i == 0) exp_q.push_back(ld[0]);
            end
        end
    end

    always @(posedge rst) begin
        for (int i = 0; i < 3; i++) acc_v[i] = 1'b0;
        exp_q.delete();
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            check($sformatf("u%0d_outputs_cyc%0d", i, cyc),
                  {27'd0, lr[i], bz[i], sv[i], so[i], dn[i]}, {27'd0, model_out(i, cyc)});
        if (sv[0]) cap = {cap[6:0], so[0]};
        if (dn[0]) begin
            if (exp_q.size() == 0) check("u0_done_without_word", exp_q.size(), 1);
            else check($sformatf("u0_word_cyc%0d", cyc), cap, exp_q.pop_front());
        end
    end

    // Called on a negedge; returns on the negedge right after the accept edge.
    task automatic send(input int i, input logic [7:0] w, input bit keep, output int acc_cyc);
        lv[i] = 1'b1;
        ld[i] = w;
        for (int t = 0; t < 300 && !lr[i]; t++) @(negedge clk);
        if (!lr[i]) begin
            tests++;
            fails++;
            $display("FAIL u%0d_handshake_timeout load_ready=%0b required=1", i, lr[i]);
            lv[i] = 1'b0;
            acc_cyc = -1;
            return;
        end
        @(negedge clk);
        acc_cyc = cyc;
        if (!keep) begin
            lv[i] = 1'b0;
            ld[i] = 8'($urandom);
        end
    endtask

    task automatic rand_stream(input int i);
        int a;
        repeat (15) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(i, 8'($urandom), 1'($urandom_range(0, 1)), a);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
                lv[i] = 1'b1;
                ld[i] = 8'($urandom);
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            lv[i] = 1'b0;
        end
    endtask

    initial begin
        int         a;
        int         b;
        logic [9:0] t_sout;
        logic [9:0] t_done;
        logic [9:0] t_rdy;
        logic [7:0] c3;

        for (int i = 0; i < 3; i++) begin
            lv[i] = 1'b0;
            ld[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset_values_u%0d", i), {lr[i], bz[i], sv[i], so[i], dn[i]}, 5'b10000);
        rst = 1'b0;

        // 8'hA5 MSB first, accepted on the very first edge after reset release
        t_sout = 10'b1010010100;
        t_done = 10'b0000000010;
        t_rdy  = 10'b0000000001;
        send(0, 8'hA5, 1'b0, a);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("a5_sout_%0d", j), so[0], t_sout[9-j]);
            check($sformatf("a5_valid_%0d", j), sv[0], (j < 8) ? 1 : 0);
            check($sformatf("a5_done_%0d", j), dn[0], t_done[9-j]);
            check($sformatf("a5_ready_%0d", j), lr[0], t_rdy[9-j]);
            @(negedge clk);
        end

        // 8'h01 LSB first; sout back at idle level in the done cycle
        t_sout = 10'b1000000000;
        send(1, 8'h01, 1'b0, a);
        for (int j = 0; j < 10; j++) begin
            check($sformatf("lsb01_sout_%0d", j), so[1], t_sout[9-j]);
            check($sformatf("lsb01_done_%0d", j), dn[1], t_done[9-j]);
            @(negedge clk);
        end

        // 8'hC3 at 4 clocks per bit: 32 data cycles, done at E+32, ready at E+33
        c3 = 8'hC3;
        send(2, 8'hC3, 1'b0, a);
        for (int j = 0; j < 34; j++) begin
            if (j < 32) check($sformatf("c3_sout_%0d", j), so[2], c3[7-j/4]);
            check($sformatf("c3_done_%0d", j), dn[2], (j == 32) ? 1 : 0);
            check($sformatf("c3_ready_%0d", j), lr[2], (j == 33) ? 1 : 0);
            @(negedge clk);
        end

        // load_valid with 8'hFF during an 8'h5A frame must not disturb it
        send(0, 8'h5A, 1'b0, a);
        repeat (2) @(negedge clk);
        lv[0] = 1'b1;
        ld[0] = 8'hFF;
        repeat (3) @(negedge clk);
        lv[0] = 1'b0;
        repeat (6) @(negedge clk);

        // asynchronous reset during bit 3
        send(0, 8'hA5, 1'b0, a);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_reset_u0", {lr[0], bz[0], sv[0], so[0], dn[0]}, 5'b10000);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // continuous load_valid: back-to-back frames spaced by W*cpb+2 edges
        send(0, 8'h12, 1'b1, a);
        send(0, 8'h34, 1'b0, b);
        check("b2b_spacing_u0", b - a, 10);
        send(2, 8'h3C, 1'b1, a);
        send(2, 8'h81, 1'b0, b);
        check("b2b_spacing_u2", b - a, 34);
        repeat (40) @(negedge clk);

        fork
            rand_stream(0);
            rand_stream(1);
            rand_stream(2);
        join
        repeat (45) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
